warp_writeback_unit: RTL and testbench

Writeback stage directly upstream of the threading register file. Accepts one warp-wide result bundle per instruction: one DATA_W result per thread, an active-thread mask, a destination register and a predicate flag. Serialises the bundle onto the register file's single write port, one active thread per cycle, driving write_thread/write_rd/write_data or predicate_write_en/predicate_in. Applies backpressure to the execute stage while draining.

---
 rtl/gpu_pkg.sv | 15 +
 rtl/find_first_set.sv | 14 +
 rtl/warp_writeback_unit.sv | 63 ++++++
 tb/tb_warp_writeback_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared constants and types for the warp writeback path
package gpu_pkg;
  localparam int NUM_THREADS = 16;
  localparam int DATA_W = 18;
  localparam int REG_ADDR_W = 4;
  localparam int TID_W = $clog2(NUM_THREADS);
  typedef enum logic {IDLE, DRAIN} wb_state_t;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic is_pred;
    logic [NUM_THREADS-1:0] mask;
    logic [NUM_THREADS-1:0][DATA_W-1:0] data;
    logic [NUM_THREADS-1:0] pred;
  } wb_bundle_t;
endpackage

// File: rtl/find_first_set.sv
// find_first_set: lowest-set-bit priority encoder with valid flag
module find_first_set
  import gpu_pkg::*;
(
  input  logic [NUM_THREADS-1:0] vec,
  output logic [TID_W-1:0]       idx,
  output logic                   valid
);
  always_comb begin
    idx = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) if (vec[i]) idx = TID_W'(i);
  end
  assign valid = |vec;
endmodule

// File: rtl/warp_writeback_unit.sv
// warp_writeback_unit: serialises a warp result bundle onto the single register-file write port
module warp_writeback_unit
  import gpu_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [REG_ADDR_W-1:0]         in_rd,
  input  logic                          in_is_pred,
  input  logic [NUM_THREADS-1:0]        in_mask,
  input  logic [NUM_THREADS*DATA_W-1:0] in_data,
  input  logic [NUM_THREADS-1:0]        in_pred,
  output logic                          write_en,
  output logic [TID_W-1:0]              write_thread,
  output logic [REG_ADDR_W-1:0]         write_rd,
  output logic [DATA_W-1:0]             write_data,
  output logic                          predicate_write_en,
  output logic                          predicate_in,
  output logic                          busy,
  output logic                          done
);
  wb_state_t state, state_n;
  wb_bundle_t b, src;
  logic [TID_W-1:0] t;
  logic any, accept, issue, finish;
  assign in_ready = state == IDLE;
  assign accept = in_valid && in_ready;
  // The first write issues straight from the incoming bundle so it lands one cycle after acceptance
  assign src = in_ready ? {in_rd, in_is_pred, in_mask, in_data, in_pred} : b;
  find_first_set u_ffs (.vec(src.mask), .idx(t), .valid(any));
  assign issue = (accept || state == DRAIN) && any;
  assign finish = (accept || state == DRAIN) && !any;
  always_comb state_n = issue ? DRAIN : finish ? IDLE : state;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      b <= '0;
      write_en <= 1'b0;
      write_thread <= '0;
      write_rd <= '0;
      write_data <= '0;
      predicate_write_en <= 1'b0;
      predicate_in <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      busy <= state_n == DRAIN;
      done <= finish;
      write_en <= issue && !src.is_pred && src.rd != '0;
      predicate_write_en <= issue && src.is_pred;
      if (accept) b <= src;
      if (issue) begin
        b.mask[t] <= 1'b0;
        write_thread <= t;
        write_rd <= src.rd;
        write_data <= src.data[t];
        predicate_in <= src.pred[t];
      end
    end
  end
endmodule

// File: tb/tb_warp_writeback_unit.sv
// tb_warp_writeback_unit: directed self-checking bench for warp_writeback_unit
module tb_warp_writeback_unit;
  import gpu_pkg::*;
  logic clk = 0, rst = 1, in_valid = 0, in_is_pred = 0;
  logic [REG_ADDR_W-1:0] in_rd = '0;
  logic [NUM_THREADS-1:0] in_mask = '0, in_pred = '0;
  logic [NUM_THREADS*DATA_W-1:0] in_data = '0;
  logic in_ready, write_en, predicate_write_en, predicate_in, busy, done;
  logic [TID_W-1:0] write_thread;
  logic [REG_ADDR_W-1:0] write_rd;
  logic [DATA_W-1:0] write_data;
  int passed = 0, fails = 0, total = 0;
  warp_writeback_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_is_pred(in_is_pred), .in_mask(in_mask), .in_data(in_data), .in_pred(in_pred),
    .write_en(write_en), .write_thread(write_thread), .write_rd(write_rd),
    .write_data(write_data), .predicate_write_en(predicate_write_en),
    .predicate_in(predicate_in), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_out(input string tag);
    chk({tag, " write_en"}, write_en, 0);
    chk({tag, " pred_we"}, predicate_write_en, 0);
    chk({tag, " done"}, done, 0);
  endtask
  task automatic load(input logic [NUM_THREADS-1:0] m, input logic [REG_ADDR_W-1:0] rd, input logic p);
    in_mask = m;
    in_rd = rd;
    in_is_pred = p;
    in_valid = 1;
  endtask
  task automatic send(input logic [NUM_THREADS-1:0] m, input logic [REG_ADDR_W-1:0] rd, input logic p);
    chk("ready before send", in_ready, 1);
    load(m, rd, p);
    step();
    in_valid = 0;
  endtask
  task automatic data_write(input string tag, input int th, input int rd, input int d);
    chk({tag, " write_en"}, write_en, 1);
    chk({tag, " thread"}, write_thread, th);
    chk({tag, " rd"}, write_rd, rd);
    chk({tag, " data"}, write_data, d);
    chk({tag, " pred_we"}, predicate_write_en, 0);
    chk({tag, " ready"}, in_ready, 0);
    chk({tag, " busy"}, busy, 1);
  endtask
  task automatic retired(input string tag);
    chk({tag, " done"}, done, 1);
    chk({tag, " ready"}, in_ready, 1);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " write_en"}, write_en, 0);
    chk({tag, " pred_we"}, predicate_write_en, 0);
  endtask
  initial begin
    #1;
    chk("reset write_en", write_en, 0);
    chk("reset thread", write_thread, 0);
    chk("reset rd", write_rd, 0);
    chk("reset data", write_data, 0);
    chk("reset pred_we", predicate_write_en, 0);
    chk("reset pred_in", predicate_in, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset ready", in_ready, 1);
    in_valid = 1;
    in_mask = 16'h0001;
    step();
    in_valid = 0;
    chk("handshake in reset ignored", busy, 0);
    rst = 0;
    step();
    idle_out("post reset");
    for (int i = 0; i < NUM_THREADS; i++) in_data[i*DATA_W +: DATA_W] = DATA_W'(i * 10);
    send(16'hFFFF, 3, 0);
    for (int i = 0; i < NUM_THREADS; i++) begin
      data_write($sformatf("full t%0d", i), i, 3, i * 10);
      step();
    end
    retired("full end");
    step();
    chk("full done one cycle", done, 0);
    in_data = '0;
    in_data[0 +: DATA_W] = 18'h3FFFF;
    in_data[15*DATA_W +: DATA_W] = 18'h00001;
    send(16'h8001, 3, 0);
    data_write("sparse t0", 0, 3, 18'h3FFFF);
    step();
    data_write("sparse t15", 15, 3, 1);
    step();
    retired("sparse end");
    step();
    in_pred = 16'h0050;
    send(16'h00F0, 9, 1);
    for (int i = 4; i < 8; i++) begin
      chk($sformatf("pred t%0d we", i), predicate_write_en, 1);
      chk($sformatf("pred t%0d thread", i), write_thread, i);
      chk($sformatf("pred t%0d val", i), predicate_in, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("pred t%0d write_en", i), write_en, 0);
      step();
    end
    retired("pred end");
    step();
    send(16'h0000, 2, 0);
    retired("zero mask");
    step();
    idle_out("zero mask after");
    send(16'h0003, 0, 0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rd0 t%0d write_en", i), write_en, 0);
      chk($sformatf("rd0 t%0d busy", i), busy, 1);
      chk($sformatf("rd0 t%0d thread", i), write_thread, i);
      step();
    end
    retired("rd0 end");
    step();
    for (int i = 0; i < NUM_THREADS; i++) in_data[i*DATA_W +: DATA_W] = DATA_W'(i + 100);
    send(16'hFFFF, 6, 0);
    step();
    step();
    step();
    step();
    data_write("pre reset t4", 4, 6, 104);
    #3 rst = 1;
    #1;
    chk("mid rst write_en", write_en, 0);
    chk("mid rst thread", write_thread, 0);
    chk("mid rst data", write_data, 0);
    chk("mid rst rd", write_rd, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst ready", in_ready, 1);
    step();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      idle_out($sformatf("after rst %0d", i));
      chk($sformatf("after rst %0d ready", i), in_ready, 1);
    end
    in_data[2*DATA_W +: DATA_W] = 18'h155;
    send(16'h0004, 5, 0);
    data_write("post rst t2", 2, 5, 18'h155);
    step();
    retired("post rst end");
    step();
    in_data = '0;
    in_data[0 +: DATA_W] = 18'h0000A;
    in_data[4*DATA_W +: DATA_W] = 18'h0000B;
    chk("bp ready", in_ready, 1);
    load(16'h0011, 7, 0);
    step();
    in_data = '0;
    in_data[1*DATA_W +: DATA_W] = 18'h0000C;
    in_data[2*DATA_W +: DATA_W] = 18'h0000D;
    load(16'h0006, 8, 0);
    data_write("bp A t0", 0, 7, 18'h0000A);
    step();
    data_write("bp A t4", 4, 7, 18'h0000B);
    step();
    retired("bp A end");
    step();
    in_valid = 0;
    data_write("bp B t1", 1, 8, 18'h0000C);
    step();
    data_write("bp B t2", 2, 8, 18'h0000D);
    step();
    retired("bp B end");
    step();
    idle_out("bp idle");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
